// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - state encoding and line-source select codes for the UART transmit controller
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] START_SEL = 2'b00;
   localparam logic [1:0] STOP_SEL  = 2'b01;
   localparam logic [1:0] DATA_SEL  = 2'b10;
   localparam logic [1:0] PAR_SEL   = 2'b11;

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - frame parity bit captured at byte acceptance
module uart_parity_calc #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  PAR_TYP,
   input  logic                  ACCEPT,
   output logic                  PAR_BIT
);

   // Hold the parity of the accepted byte for the whole frame; odd type inverts it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         PAR_BIT <= 1'b0;
      end else if (ACCEPT) begin
         PAR_BIT <= (^P_DATA) ^ PAR_TYP;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer with output line mux
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  DATA_VALID,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  SER_DATA,
   input  logic                  SER_DONE,
   output logic                  SER_EN,
   output logic                  Busy,
   output logic [1:0]            MUX_SEL,
   output logic                  TX_OUT,
   output logic                  SEQ_ERR
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

   tx_state_t     state, state_nxt;
   logic [CW-1:0] bit_cnt, cnt_nxt;
   logic          par_en_r;
   logic          par_bit;
   logic          busy_r, ser_en_r, seq_err_r;
   logic          accept;
   logic          last_bit;
   logic          busy_nxt, ser_en_nxt, seq_err_nxt;

   assign accept   = (state == IDLE) && DATA_VALID;
   assign last_bit = (bit_cnt == LAST_CNT);

   uart_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .CLK     (CLK),
      .RST     (RST),
      .P_DATA  (P_DATA),
      .PAR_TYP (PAR_TYP),
      .ACCEPT  (accept),
      .PAR_BIT (par_bit)
   );

   // Frame sequencing: next state and bit counter; counter is cleared when DATA is entered.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_cnt;
      case (state)
         IDLE: begin
            if (DATA_VALID) state_nxt = START;
         end
         START: begin
            state_nxt = DATA;
            cnt_nxt   = '0;
         end
         DATA: begin
            if (last_bit) state_nxt = par_en_r ? PARITY : STOP;
            else          cnt_nxt   = bit_cnt + 1'b1;
         end
         PARITY:  state_nxt = STOP;
         STOP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Busy, shift-enable and sequence error are precomputed so they leave the block as flops.
   always_comb begin
      busy_nxt    = (state_nxt != IDLE);
      ser_en_nxt  = (state_nxt == START) ||
                    ((state_nxt == DATA) && (cnt_nxt != LAST_CNT));
      seq_err_nxt = 1'b0;
      if (state == DATA) begin
         seq_err_nxt = last_bit ? !SER_DONE : SER_DONE;
      end
   end

   // State, counter, captured parity enable and registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         par_en_r  <= 1'b0;
         busy_r    <= 1'b0;
         ser_en_r  <= 1'b0;
         seq_err_r <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= cnt_nxt;
         busy_r    <= busy_nxt;
         ser_en_r  <= ser_en_nxt;
         seq_err_r <= seq_err_nxt;
         if (accept) par_en_r <= PAR_EN;
      end
   end

   // Line-source select decoded from the current state; idle line sits on the stop level.
   always_comb begin
      MUX_SEL = STOP_SEL;
      case (state)
         START:   MUX_SEL = START_SEL;
         DATA:    MUX_SEL = DATA_SEL;
         PARITY:  MUX_SEL = PAR_SEL;
         default: MUX_SEL = STOP_SEL;
      endcase
   end

   // Output line mux.
   always_comb begin
      TX_OUT = 1'b1;
      case (MUX_SEL)
         START_SEL: TX_OUT = 1'b0;
         STOP_SEL:  TX_OUT = 1'b1;
         DATA_SEL:  TX_OUT = SER_DATA;
         PAR_SEL:   TX_OUT = par_bit;
         default:   TX_OUT = 1'b1;
      endcase
   end

   assign Busy    = busy_r;
   assign SER_EN  = ser_en_r;
   assign SEQ_ERR = seq_err_r;

endmodule
